// File: rtl/mcmc_formula_pkg.sv
// mcmc_formula_pkg: formula geometry helpers and loader state encoding shared by checker, loader and bench
package mcmc_formula_pkg;
    localparam int unsigned DEF_INT_COEFF    = 4;
    localparam int unsigned DEF_BOOL_COEFF   = 2;
    localparam int unsigned DEF_INT_VAR_IDX  = 1;
    localparam int unsigned DEF_BOOL_VAR_IDX = 1;
    localparam int unsigned DEF_CLAUSE_IDX   = 1;
    function automatic int unsigned integer_width(input int unsigned coeff, input int unsigned var_idx);
        return ((1 << var_idx) + 1) * coeff;
    endfunction
    function automatic int unsigned boolean_width(input int unsigned coeff, input int unsigned var_idx);
        return coeff * (1 << var_idx);
    endfunction
    function automatic int unsigned clause_count(input int unsigned idx);
        return 1 << idx;
    endfunction
    typedef enum logic [1:0] {
        LOADER_IDLE,
        LOADER_READ,
        LOADER_DRAIN
    } loader_state_e;
endpackage

// File: rtl/clause_memory_loader.sv
// clause_memory_loader: streams N clauses from the formula ROMs into the checker clause bank on start.
//   in_clk/in_reset                 clock, synchronous active-high reset
//   in_start/in_num_clauses         load request and clause count (clamped to NC)
//   out_mem_address/read_enable     shared ROM read port; data returns one cycle later
//   in_mem_data_integer/boolean     ROM data
//   out_clause_*                    registered clause write to the checker bank
//   out_checker_enable              per-clause enable mask, bit set as each clause lands
//   out_busy/out_done               load in progress / one-cycle completion pulse
module clause_memory_loader
    import mcmc_formula_pkg::*;
#(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = DEF_INT_COEFF,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = DEF_BOOL_COEFF,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = DEF_INT_VAR_IDX,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = DEF_BOOL_VAR_IDX,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = DEF_CLAUSE_IDX,
    localparam int IW = integer_width(MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT, MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX),
    localparam int BW = boolean_width(MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT, MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX),
    localparam int CI = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int NC = clause_count(MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)
) (
    input  logic          in_clk,
    input  logic          in_reset,
    input  logic          in_start,
    input  logic [CI:0]   in_num_clauses,
    output logic [CI-1:0] out_mem_address,
    output logic          out_mem_read_enable,
    input  logic [IW-1:0] in_mem_data_integer,
    input  logic [BW-1:0] in_mem_data_boolean,
    output logic [IW-1:0] out_clause_coefficients_integer,
    output logic [BW-1:0] out_clause_coefficients_boolean,
    output logic [CI-1:0] out_clause_index,
    output logic          out_clause_write,
    output logic [NC-1:0] out_checker_enable,
    output logic          out_busy,
    output logic          out_done
);
    localparam logic [CI:0] NC_W = (CI+1)'(NC);
    loader_state_e state_q, state_d;
    logic [CI:0]   n_q, n_d, n_clamped;
    logic [CI-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, idx_q;
    logic [IW-1:0] int_q;
    logic [BW-1:0] bool_q;
    logic [NC-1:0] en_q;
    logic          rd_v_q, wr_q, busy_q, done_pend_q, done_q;
    logic          accept, last, fin;
    always_comb begin
        n_clamped = in_num_clauses > NC_W ? NC_W : in_num_clauses;
        accept    = state_q == LOADER_IDLE && !busy_q && in_start;
        last      = {1'b0, rd_ptr_q} == n_q - 1'b1;
        state_d   = state_q;
        n_d       = n_q;
        rd_ptr_d  = rd_ptr_q;
        fin       = 1'b0;
        case (state_q)
            LOADER_IDLE: if (accept) begin
                n_d      = n_clamped;
                rd_ptr_d = '0;
                fin      = n_clamped == '0;
                state_d  = n_clamped == '0 ? LOADER_IDLE : LOADER_READ;
            end
            LOADER_READ: begin
                state_d  = last ? LOADER_DRAIN : LOADER_READ;
                rd_ptr_d = last ? rd_ptr_q : rd_ptr_q + 1'b1;
            end
            LOADER_DRAIN: begin
                state_d = LOADER_IDLE;
                fin     = 1'b1;
            end
            default: state_d = LOADER_IDLE;
        endcase
    end
    // done is delayed one cycle past the last write so the checker sees a fully populated bank
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q     <= LOADER_IDLE;
            n_q         <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_v_q      <= 1'b0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            int_q       <= '0;
            bool_q      <= '0;
            en_q        <= '0;
            busy_q      <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= rd_ptr_q;
            rd_v_q      <= state_q == LOADER_READ;
            wr_q        <= rd_v_q;
            if (rd_v_q) begin
                idx_q  <= wr_ptr_q;
                int_q  <= in_mem_data_integer;
                bool_q <= in_mem_data_boolean;
            end
            en_q        <= accept ? '0 : rd_v_q ? en_q | (NC'(1) << wr_ptr_q) : en_q;
            busy_q      <= accept ? n_clamped != '0 : done_pend_q ? 1'b0 : busy_q;
            done_pend_q <= fin;
            done_q      <= done_pend_q;
        end
    end
    assign out_mem_read_enable             = state_q == LOADER_READ;
    assign out_mem_address                 = state_q == LOADER_READ ? rd_ptr_q : '0;
    assign out_clause_coefficients_integer = int_q;
    assign out_clause_coefficients_boolean = bool_q;
    assign out_clause_index                = idx_q;
    assign out_clause_write                = wr_q;
    assign out_checker_enable              = en_q;
    assign out_busy                        = busy_q;
    assign out_done                        = done_q;
endmodule

// File: tb/tb_clause_memory_loader.sv
// tb_clause_memory_loader: directed self-checking bench for clause_memory_loader
module tb_clause_memory_loader;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]  num = '0;
    logic [0:0]  addr, idx;
    logic        rd_en, wr, busy, done;
    logic [11:0] mi = '0, oi;
    logic [3:0]  mb = '0, ob;
    logic [1:0]  en;
    logic [11:0] rom_i [2];
    logic [3:0]  rom_b [2];
    int checks = 0, failures = 0;
    int writes_n = 0, reads1_n = 0, reads_n = 0, done_n = 0;
    int w0, r1, r0, d0;

    clause_memory_loader dut (
        .in_clk(clk), .in_reset(rst), .in_start(start), .in_num_clauses(num),
        .out_mem_address(addr), .out_mem_read_enable(rd_en),
        .in_mem_data_integer(mi), .in_mem_data_boolean(mb),
        .out_clause_coefficients_integer(oi), .out_clause_coefficients_boolean(ob),
        .out_clause_index(idx), .out_clause_write(wr), .out_checker_enable(en),
        .out_busy(busy), .out_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            mi <= rom_i[addr];
            mb <= rom_b[addr];
            reads_n <= reads_n + 1;
            if (addr == 1'b1) reads1_n <= reads1_n + 1;
        end
        if (wr) writes_n <= writes_n + 1;
        if (done) done_n <= done_n + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) step();
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        rom_i[0] = 12'h1A3; rom_i[1] = 12'h0F2;
        rom_b[0] = 4'b0110; rom_b[1] = 4'b1001;
        repeat (3) step();
        chk("rst_write", 32'(wr), 0);
        chk("rst_enable", 32'(en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rden", 32'(rd_en), 0);
        chk("rst_data", {oi, ob}, 0);
        rst = 1'b0;
        step();
        // full load, N=2
        start = 1'b1; num = 2'd2;
        step();
        start = 1'b0;
        chk("full_busy", 32'(busy), 1);
        chk("full_rd0", {rd_en, addr}, {1'b1, 1'b0});
        step();
        chk("full_rd1", {rd_en, addr}, {1'b1, 1'b1});
        chk("full_nowrite_e1", 32'(wr), 0);
        step();
        chk("full_w0", {wr, idx, oi, ob}, {1'b1, 1'b0, 12'h1A3, 4'b0110});
        chk("full_en01", 32'(en), 2'b01);
        chk("full_rd_off", 32'(rd_en), 0);
        step();
        chk("full_w1", {wr, idx, oi, ob}, {1'b1, 1'b1, 12'h0F2, 4'b1001});
        chk("full_en11", 32'(en), 2'b11);
        chk("full_done_early", 32'(done), 0);
        step();
        chk("full_done", {done, busy, wr}, {1'b1, 1'b0, 1'b0});
        chk("full_hold", {oi, ob}, {12'h0F2, 4'b1001});
        step();
        chk("full_done_pulse", 32'(done), 0);
        // partial, N=1
        r1 = reads1_n; w0 = writes_n;
        start = 1'b1; num = 2'd1;
        step();
        start = 1'b0;
        chk("part_en_clear", 32'(en), 0);
        chk("part_busy", 32'(busy), 1);
        step();
        step();
        chk("part_w0", {wr, idx, oi, ob}, {1'b1, 1'b0, 12'h1A3, 4'b0110});
        chk("part_en01", 32'(en), 2'b01);
        step();
        chk("part_done", 32'(done), 1);
        chk("part_no_addr1", reads1_n - r1, 0);
        chk("part_writes", writes_n - w0, 1);
        step();
        // N=0
        w0 = writes_n;
        start = 1'b1; num = 2'd0;
        step();
        start = 1'b0;
        chk("zero_state", {busy, en, done}, 0);
        step();
        chk("zero_done", 32'(done), 1);
        step();
        chk("zero_done_pulse", 32'(done), 0);
        chk("zero_writes", writes_n - w0, 0);
        // N=3 clamps to 2
        w0 = writes_n; r0 = reads_n;
        start = 1'b1; num = 2'd3;
        step();
        start = 1'b0;
        wait_done("clamp_done");
        chk("clamp_writes", writes_n - w0, 2);
        chk("clamp_reads", reads_n - r0, 2);
        chk("clamp_en", 32'(en), 2'b11);
        step();
        // start while busy is ignored
        w0 = writes_n; d0 = done_n;
        start = 1'b1; num = 2'd2;
        step();
        num = 2'd1;
        step();
        start = 1'b0;
        wait_done("busy_done");
        repeat (6) step();
        chk("busy_writes", writes_n - w0, 2);
        chk("busy_one_done", done_n - d0, 1);
        chk("busy_en", 32'(en), 2'b11);
        // reset mid-load
        d0 = done_n;
        start = 1'b1; num = 2'd2;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid_first_write", {wr, idx}, {1'b1, 1'b0});
        rst = 1'b1;
        step();
        chk("mid_rst_out", {wr, en, busy, done, rd_en}, 0);
        rst = 1'b0;
        repeat (5) step();
        chk("mid_no_done", done_n - d0, 0);
        w0 = writes_n;
        start = 1'b1; num = 2'd2;
        step();
        start = 1'b0;
        step();
        step();
        chk("re_w0", {wr, idx, oi, ob}, {1'b1, 1'b0, 12'h1A3, 4'b0110});
        step();
        chk("re_w1", {wr, idx, oi, ob}, {1'b1, 1'b1, 12'h0F2, 4'b1001});
        wait_done("re_done");
        chk("re_writes", writes_n - w0, 2);
        chk("re_en", 32'(en), 2'b11);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
